// File: rtl/tile_addr_gen.sv
// Walks a rows x cols tile and streams one byte address per element, first address the cycle after start.
// addr_valid holds with stable address/indices until addr_ready; back-to-back handshakes give one address per cycle.
package accelerator_common_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int IDX_WIDTH  = 8;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [IDX_WIDTH-1:0]  idx_t;
  localparam addr_t NULL_ADDR = 32'h9999_9999;
endpackage

module tile_addr_gen #(
  parameter int ADDR_WIDTH = accelerator_common_pkg::ADDR_WIDTH,
  parameter int IDX_WIDTH  = accelerator_common_pkg::IDX_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [IDX_WIDTH-1:0]  i_num_rows,
  input  logic [IDX_WIDTH-1:0]  i_num_cols,
  input  logic [ADDR_WIDTH-1:0] i_row_stride,
  input  logic [ADDR_WIDTH-1:0] i_elem_stride,
  output logic                  o_addr_valid,
  input  logic                  i_addr_ready,
  output logic [ADDR_WIDTH-1:0] o_addr_out,
  output logic [IDX_WIDTH-1:0]  o_row_idx,
  output logic [IDX_WIDTH-1:0]  o_col_idx,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] LP_NULL_ADDR = ADDR_WIDTH'(accelerator_common_pkg::NULL_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Extents are held as count-1 so a 255-wide tile compares without overflow.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] row_stride;
    logic [ADDR_WIDTH-1:0] elem_stride;
    logic [IDX_WIDTH-1:0]  rows_m1;
    logic [IDX_WIDTH-1:0]  cols_m1;
  } cfg_t;

  state_t                r_state;
  state_t                w_next_state;
  cfg_t                  r_cfg;
  logic [ADDR_WIDTH-1:0] r_row_addr;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [IDX_WIDTH-1:0]  r_row_idx;
  logic [IDX_WIDTH-1:0]  r_col_idx;

  logic w_empty;
  logic w_hs;
  logic w_row_end;
  logic w_last_elem;

  assign w_empty     = (i_num_rows == '0) || (i_num_cols == '0);
  assign w_hs        = (r_state == S_RUN) && i_addr_ready;
  assign w_row_end   = (r_col_idx == r_cfg.cols_m1);
  assign w_last_elem = w_row_end && (r_row_idx == r_cfg.rows_m1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = w_empty ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_hs && w_last_elem) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cfg      <= '0;
      r_row_addr <= '0;
      r_cur_addr <= '0;
      r_row_idx  <= '0;
      r_col_idx  <= '0;
    end else if (r_state == S_IDLE) begin
      if (i_start) begin
        r_cfg.row_stride  <= i_row_stride;
        r_cfg.elem_stride <= i_elem_stride;
        r_cfg.rows_m1     <= i_num_rows - 1'b1;
        r_cfg.cols_m1     <= i_num_cols - 1'b1;
        r_row_addr        <= i_base_addr;
        r_cur_addr        <= i_base_addr;
        r_row_idx         <= '0;
        r_col_idx         <= '0;
      end
    end else if (w_hs && !w_last_elem) begin
      if (!w_row_end) begin
        r_col_idx  <= r_col_idx + 1'b1;
        r_cur_addr <= r_cur_addr + r_cfg.elem_stride;
      end else begin
        // Each row restarts from the accumulated row base, never from the column walk.
        r_col_idx  <= '0;
        r_row_idx  <= r_row_idx + 1'b1;
        r_row_addr <= r_row_addr + r_cfg.row_stride;
        r_cur_addr <= r_row_addr + r_cfg.row_stride;
      end
    end
  end

  assign o_addr_valid = (r_state == S_RUN);
  assign o_addr_out   = o_addr_valid ? r_cur_addr : LP_NULL_ADDR;
  assign o_last       = o_addr_valid && w_last_elem;
  assign o_row_idx    = r_row_idx;
  assign o_col_idx    = r_col_idx;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_tile_addr_gen.sv
// Directed bench for tile_addr_gen: hand-computed address sequences, backpressure, empty tile, wrap, start filtering, async reset.
module tb_tile_addr_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  num_rows;
  logic [7:0]  num_cols;
  logic [31:0] row_stride;
  logic [31:0] elem_stride;
  logic        addr_valid;
  logic        addr_ready;
  logic [31:0] addr_out;
  logic [7:0]  row_idx;
  logic [7:0]  col_idx;
  logic        last;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_addr [6] = '{32'h1000, 32'h1004, 32'h1008, 32'h1100, 32'h1104, 32'h1108};
  logic [7:0]  exp_row  [6] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
  logic [7:0]  exp_col  [6] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
  logic        rdy_pat  [24] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  tile_addr_gen dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_base_addr   (base_addr),
    .i_num_rows    (num_rows),
    .i_num_cols    (num_cols),
    .i_row_stride  (row_stride),
    .i_elem_stride (elem_stride),
    .o_addr_valid  (addr_valid),
    .i_addr_ready  (addr_ready),
    .o_addr_out    (addr_out),
    .o_row_idx     (row_idx),
    .o_col_idx     (col_idx),
    .o_last        (last),
    .o_busy        (busy),
    .o_done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(addr_valid), 32'd0);
    chk({tag, "_addr"},  addr_out, 32'h9999_9999);
    chk({tag, "_last"},  32'(last), 32'd0);
  endtask

  task automatic cfg_2x3(input logic [31:0] base);
    base_addr   = base;
    num_rows    = 8'd2;
    num_cols    = 8'd3;
    row_stride  = 32'h100;
    elem_stride = 32'd4;
  endtask

  // Issues start for the 2x3 tile and walks it with ready held high.
  task automatic run_2x3_full(input string tag);
    cfg_2x3(32'h1000);
    addr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk({tag, "_valid"}, 32'(addr_valid), 32'd1);
      chk({tag, "_addr"},  addr_out, exp_addr[i]);
      chk({tag, "_row"},   32'(row_idx), 32'(exp_row[i]));
      chk({tag, "_col"},   32'(col_idx), 32'(exp_col[i]));
      chk({tag, "_last"},  32'(last), (i == 5) ? 32'd1 : 32'd0);
      chk({tag, "_busy"},  32'(busy), 32'd1);
      chk({tag, "_done"},  32'(done), 32'd0);
      tick();
    end
    chk({tag, "_done_pulse"}, 32'(done), 32'd1);
    chk({tag, "_done_busy"},  32'(busy), 32'd1);
    chk_idle({tag, "_donecyc"});
    tick();
    chk({tag, "_done_fall"}, 32'(done), 32'd0);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk_idle({tag, "_after"});
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    addr_ready = 1'b0;
    cfg_2x3(32'h0);
    #2;
    chk_idle("reset");
    chk("reset_row",  32'(row_idx), 32'd0);
    chk("reset_col",  32'(col_idx), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_idle("idle");

    run_2x3_full("t1");

    // Backpressure: address/indices must hold while ready is low.
    begin
      int k;
      k = 0;
      cfg_2x3(32'h1000);
      addr_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 24; c++) begin
        if (k < 6) begin
          addr_ready = rdy_pat[c];
          chk("bp_valid", 32'(addr_valid), 32'd1);
          chk("bp_addr",  addr_out, exp_addr[k]);
          chk("bp_row",   32'(row_idx), 32'(exp_row[k]));
          chk("bp_col",   32'(col_idx), 32'(exp_col[k]));
          chk("bp_last",  32'(last), (k == 5) ? 32'd1 : 32'd0);
          tick();
          if (rdy_pat[c]) k++;
        end
      end
      chk("bp_count", 32'(k), 32'd6);
      chk("bp_done",  32'(done), 32'd1);
      chk_idle("bp_donecyc");
      addr_ready = 1'b1;
      tick();
      chk("bp_idle_busy", 32'(busy), 32'd0);
    end

    // Empty tile: straight to DONE, nothing emitted.
    base_addr = 32'h4000;
    num_rows  = 8'd0;
    num_cols  = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_idle("empty");
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_busy", 32'(busy), 32'd1);
    tick();
    chk_idle("empty_after");
    chk("empty_done_fall", 32'(done), 32'd0);
    chk("empty_busy_fall", 32'(busy), 32'd0);

    // Address wrap past 32'hFFFF_FFFF.
    base_addr   = 32'hFFFF_FFFC;
    num_rows    = 8'd1;
    num_cols    = 8'd2;
    row_stride  = 32'h100;
    elem_stride = 32'd8;
    addr_ready  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wrap_addr0", addr_out, 32'hFFFF_FFFC);
    chk("wrap_last0", 32'(last), 32'd0);
    tick();
    chk("wrap_addr1", addr_out, 32'h0000_0004);
    chk("wrap_col1",  32'(col_idx), 32'd1);
    chk("wrap_last1", 32'(last), 32'd1);
    tick();
    chk("wrap_done", 32'(done), 32'd1);
    tick();

    // Start mid-tile with different config is ignored.
    cfg_2x3(32'h1000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        base_addr   = 32'h5000;
        num_rows    = 8'd9;
        num_cols    = 8'd9;
        row_stride  = 32'h40;
        elem_stride = 32'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      chk("mid_addr", addr_out, exp_addr[i]);
      chk("mid_last", 32'(last), (i == 5) ? 32'd1 : 32'd0);
      tick();
    end
    chk("mid_done", 32'(done), 32'd1);
    // Start during the done pulse is ignored.
    base_addr = 32'h2000;
    num_rows  = 8'd1;
    num_cols  = 8'd1;
    start = 1'b1;
    tick();
    chk_idle("donestart");
    chk("donestart_busy", 32'(busy), 32'd0);
    // Start in the first idle cycle is accepted.
    tick();
    start = 1'b0;
    chk("idlestart_valid", 32'(addr_valid), 32'd1);
    chk("idlestart_addr",  addr_out, 32'h2000);
    chk("idlestart_last",  32'(last), 32'd1);
    tick();
    chk("idlestart_done", 32'(done), 32'd1);
    tick();

    // Asynchronous reset after three addresses.
    cfg_2x3(32'h1000);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("prerst_addr", addr_out, 32'h1100);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("arst");
    chk("arst_row",  32'(row_idx), 32'd0);
    chk("arst_col",  32'(col_idx), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("postrst_done", 32'(done), 32'd0);
    chk_idle("postrst");
    tick();
    run_2x3_full("fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tile_addr_gen.md
Name: tile_addr_gen

Overview:
- Address-generation stage that walks a 2-D tile (rows x cols) in memory and emits one byte address per element over a valid/ready stream.
- Sits directly upstream of the load/DMA engine.
- Uses the shared accelerator_common_pkg types: addr_t for addresses, idx_t for dimensions and indices, NULL_ADDR as the invalid-address marker.
- Configured by a single start pulse; reports busy and a done pulse.

Parameters:
- ADDR_WIDTH, 32 (accelerator_common_pkg::ADDR_WIDTH): address bus width.
- IDX_WIDTH, 8 (accelerator_common_pkg::IDX_WIDTH): row/column counter width.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; captures config when idle
- base_addr  input  ADDR_WIDTH  address of element (0,0)
- num_rows  input  IDX_WIDTH  tile rows; 0 means an empty tile
- num_cols  input  IDX_WIDTH  tile columns; 0 means an empty tile
- row_stride  input  ADDR_WIDTH  byte offset between rows
- elem_stride  input  ADDR_WIDTH  byte offset between columns
- addr_valid  output  1  addr_out holds a valid address
- addr_ready  input  1  downstream accepts addr_out
- addr_out  output  ADDR_WIDTH  current element address; NULL_ADDR when not valid
- row_idx  output  IDX_WIDTH  row of current element
- col_idx  output  IDX_WIDTH  column of current element
- last  output  1  current element is (num_rows-1, num_cols-1)
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse on tile completion

Behaviour:
- Reset (async, rst=1): state=IDLE, addr_valid=0, addr_out=NULL_ADDR (32'h9999_9999), row_idx=0, col_idx=0, last=0, busy=0, done=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures all config inputs into registers.
  - If num_rows==0 or num_cols==0, go to DONE; no address is emitted.
  - Otherwise go to RUN, with row_addr=base_addr, cur_addr=base_addr and both indices at 0.
- Start latency: start sampled at edge N makes addr_valid=1 after edge N, carrying base_addr.
- RUN:
  - addr_valid=1, addr_out=cur_addr, last = (row_idx==rows-1 && col_idx==cols-1).
  - Handshake occurs when addr_valid && addr_ready.
  - Without a handshake, addr_out, row_idx, col_idx and last hold stable, and addr_valid is never dropped.
  - On handshake, not at end of row: col_idx+1, cur_addr += elem_stride.
  - On handshake, at end of row and not last: col_idx=0, row_idx+1, row_addr += row_stride, cur_addr = row_addr + row_stride.
  - On handshake with last=1: go to DONE, addr_valid=0 next cycle.
  - Back-to-back handshakes sustain one address per cycle.
- DONE: done=1 for exactly one cycle, addr_valid=0, then IDLE. busy falls when IDLE is entered.
- Arithmetic:
  - All address adds are unsigned modulo 2^ADDR_WIDTH; wrap past 32'hFFFF_FFFF silently.
  - Row start is always the accumulated row_addr; per-row column offsets do not accumulate error.
  - No multipliers.
- Data path while idle: whenever addr_valid=0, addr_out=NULL_ADDR and last=0.
- Simultaneous events:
  - start while busy (RUN or DONE) is ignored; config registers unchanged.
  - start in the same cycle as the done pulse is ignored.
  - start in the first IDLE cycle after done is accepted.
- Config inputs are don't-care except in the start cycle.
- Reset mid-operation: immediate return to reset values; no done pulse; the pending tile is abandoned.
- Maximum tile: 255x255 = 65025 addresses. The counters must not overflow; the compare is against captured rows-1 and cols-1.

Test Plan:
- 2x3 tile, base=0x1000, row_stride=0x100, elem_stride=4, addr_ready tied 1 -> addresses 0x1000, 0x1004, 0x1008, 0x1100, 0x1104, 0x1108 on 6 consecutive cycles; last only on 0x1108; done one cycle after it; busy high for 7 cycles.
- Same tile, addr_ready toggling 1,0,0,1,... pseudo-randomly -> identical address sequence; addr_out, row_idx and col_idx stable while ready=0; addr_valid never drops before last.
- num_rows=0, num_cols=5, start -> no addr_valid; done pulses in the cycle after start; addr_out stays 0x9999_9999.
- 1x2 tile, base=0xFFFF_FFFC, elem_stride=8 -> addresses 0xFFFF_FFFC, then 0x0000_0004 (wrap), last on the second.
- Start pulsed again mid-tile with different base -> ignored, original sequence completes; start in the done cycle ignored; start one cycle later accepted.
- rst asserted asynchronously after 3 of 6 addresses -> outputs return to reset values immediately; no done; a subsequent start runs a full fresh tile.
